// File: rtl/requant_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : requant_pkg
//  Description : Shared types and constants for the requantization stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package requant_pkg;

    localparam int CFG_SCALE_W = 32;
    localparam int CFG_SHIFT_W = 5;
    localparam int CFG_ZP_W    = 8;
    localparam int PROD_W      = 64;

    localparam int FRAC_BITS   = 31;
    localparam int QMIN        = -128;
    localparam int QMAX        = 127;
    localparam int LAT         = 3;

    typedef struct packed {
        logic [CFG_SCALE_W-1:0]        scale;
        logic [CFG_SHIFT_W-1:0]        shift;
        logic signed [CFG_ZP_W-1:0]    zero_point;
    } requant_cfg_t;

    typedef struct packed {
        logic                          valid;
        requant_cfg_t                  cfg;
        logic signed [PROD_W-1:0]      payload;
    } requant_stage_t;

endpackage
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
//  Module      : requant_sat
//  Description : Adds a signed zero point and clamps to the signed output range.
//  Revision    : 1.0 - initial release
// ============================================================================
module requant_sat
    import requant_pkg::*;
#(
    parameter int VAL_W = 64,
    parameter int OUT_W = 8
) (
    input  logic [VAL_W-1:0] value_i,
    input  logic [OUT_W-1:0] zero_point_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    localparam logic signed [VAL_W:0] C_QMAX = (VAL_W+1)'(QMAX);
    localparam logic signed [VAL_W:0] C_QMIN = (VAL_W+1)'(QMIN);

    logic signed [VAL_W:0] w_sum;

    // One guard bit keeps the zero-point add from wrapping.
    assign w_sum = $signed({value_i[VAL_W-1], value_i})
                 + $signed({{(VAL_W+1-OUT_W){zero_point_i[OUT_W-1]}}, zero_point_i});

    always_comb begin
        data_o = w_sum[OUT_W-1:0];
        sat_o  = 1'b0;
        if (w_sum > C_QMAX) begin
            data_o = OUT_W'(QMAX);
            sat_o  = 1'b1;
        end else if (w_sum < C_QMIN) begin
            data_o = OUT_W'(QMIN);
            sat_o  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/requant.sv
`default_nettype none
// ============================================================================
//  Module      : requant
//  Description : 3-stage requantizer: Q0.31 scale, rounding shift, zp + int8 clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module requant
    import requant_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 32,
    parameter int SHIFT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    input  logic [SCALE_W-1:0] scale_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [OUT_W-1:0]   zero_point_i,
    input  logic               data_valid_i,
    input  logic [IN_W-1:0]    data_i,
    output logic               data_valid_o,
    output logic [OUT_W-1:0]   data_o,
    output logic               sat_o,
    output logic               cfg_loaded_o,
    output logic               drop_o
);

    requant_cfg_t   r_cfg;
    logic           r_cfg_loaded;
    logic           r_drop;
    requant_stage_t r_s1;
    requant_stage_t r_s2;
    logic           r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic           r_out_sat;

    requant_cfg_t   w_cfg_in;
    requant_cfg_t   w_cfg_sel;
    logic           w_accept;
    logic signed [PROD_W-1:0] w_data_ext;
    logic signed [PROD_W-1:0] w_scale_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic [6:0]               w_shamt;
    logic signed [PROD_W-1:0] w_round;
    logic signed [PROD_W-1:0] w_sum;
    logic signed [PROD_W-1:0] w_shifted;
    logic [OUT_W-1:0]         w_sat_data;
    logic                     w_sat_flag;
    logic                     w_unused;

    assign w_cfg_in  = '{scale: scale_i, shift: shift_i, zero_point: zero_point_i};
    assign w_cfg_sel = cfg_valid_i ? w_cfg_in : r_cfg;
    assign w_accept  = data_valid_i && (cfg_valid_i || r_cfg_loaded);

    // Scale is non-negative Q0.31, so |product| < 2^62 and 64 bits never wrap.
    assign w_data_ext  = {{(PROD_W-IN_W){data_i[IN_W-1]}}, data_i};
    assign w_scale_ext = {{(PROD_W-SCALE_W){1'b0}}, w_cfg_sel.scale};
    assign w_prod      = w_data_ext * w_scale_ext;

    assign w_shamt   = 7'(FRAC_BITS) + 7'(r_s1.cfg.shift);
    assign w_round   = PROD_W'(1) << (w_shamt - 7'd1);
    assign w_sum     = $signed(r_s1.payload) + w_round;
    assign w_shifted = w_sum >>> w_shamt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cfg        <= '0;
            r_cfg_loaded <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            if (cfg_valid_i) begin
                r_cfg        <= w_cfg_in;
                r_cfg_loaded <= 1'b1;
            end
            if (data_valid_i && !cfg_valid_i && !r_cfg_loaded) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1.valid <= w_accept;
            if (w_accept) begin
                r_s1.cfg     <= w_cfg_sel;
                r_s1.payload <= w_prod;
            end
            r_s2.valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_s2.cfg     <= r_s1.cfg;
                r_s2.payload <= w_shifted;
            end
        end
    end

    requant_sat #(
        .VAL_W (PROD_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .value_i      (r_s2.payload),
        .zero_point_i (r_s2.cfg.zero_point),
        .data_o       (w_sat_data),
        .sat_o        (w_sat_flag)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= r_s2.valid;
            if (r_s2.valid) begin
                r_out_data <= w_sat_data;
                r_out_sat  <= w_sat_flag;
            end
        end
    end

    // A scale with MSB set would be read as negative by downstream users.
    always_ff @(posedge clk_i) begin
        if (!rst_i && cfg_valid_i) begin
            assert (scale_i[SCALE_W-1] == 1'b0);
        end
    end

    assign w_unused = ^{r_s2.cfg.scale, r_s2.cfg.shift};

    assign data_valid_o = r_out_valid;
    assign data_o       = r_out_data;
    assign sat_o        = r_out_sat;
    assign cfg_loaded_o = r_cfg_loaded;
    assign drop_o       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_requant
//  Description : Directed self-checking bench for the requant stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_requant;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_valid_i;
    logic [31:0] scale_i;
    logic [4:0]  shift_i;
    logic [7:0]  zero_point_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        data_valid_o;
    logic [7:0]  data_o;
    logic        sat_o;
    logic        cfg_loaded_o;
    logic        drop_o;

    int n_checks = 0;
    int n_pass   = 0;

    requant u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_valid_i  (cfg_valid_i),
        .scale_i      (scale_i),
        .shift_i      (shift_i),
        .zero_point_i (zero_point_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .sat_o        (sat_o),
        .cfg_loaded_o (cfg_loaded_o),
        .drop_o       (drop_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input int d, input int s);
        chk({tag, ".valid"}, 32'(data_valid_o), 1);
        chk({tag, ".data"}, $signed(data_o), d);
        chk({tag, ".sat"}, 32'(sat_o), s);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".idle"}, 32'(data_valid_o), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg_valid_i  = 1'b0;
        data_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        cfg_valid_i  = 1'b0;
        data_valid_i = 1'b1;
        data_i       = d;
    endtask

    task automatic cfgv(input logic [31:0] sc, input logic [4:0] sh, input logic [7:0] zp);
        cfg_valid_i  = 1'b1;
        scale_i      = sc;
        shift_i      = sh;
        zero_point_i = zp;
    endtask

    int din  [6];
    int dexp [6];
    int sexp [6];

    initial begin
        rst_i = 1'b1;
        scale_i = '0; shift_i = '0; zero_point_i = '0; data_i = '0;
        idle();
        step(); step();
        chk("rst.valid", 32'(data_valid_o), 0);
        chk("rst.data", $signed(data_o), 0);
        chk("rst.sat", 32'(sat_o), 0);
        chk("rst.cfg_loaded", 32'(cfg_loaded_o), 0);
        chk("rst.drop", 32'(drop_o), 0);
        rst_i = 1'b0;
        step();

        // Rounding half toward +inf at scale 0.5, config bypassed on first beat.
        beat(10); cfgv(32'h4000_0000, 5'd0, 8'sd0); step();
        beat(11); step();
        chk_idle("t1.pre");
        beat(-11); step(); chk_out("t1.b0", 5, 0);
        chk("t1.cfg_loaded", 32'(cfg_loaded_o), 1);
        beat(-12); step(); chk_out("t1.b1", 6, 0);
        idle();    step(); chk_out("t1.b2", -5, 0);
        step();            chk_out("t1.b3", -6, 0);
        step();            chk_idle("t1.post");

        // Saturation and exact clamp boundaries.
        din  = '{1000, -1000, 254, -256, 255, -258};
        dexp = '{127,  -128,  127, -128, 127, -128};
        sexp = '{1,    1,     0,   0,    1,   1};
        for (int i = 0; i < 8; i++) begin
            if (i < 6) beat(din[i]); else idle();
            step();
            if (i >= 2) chk_out($sformatf("t2.b%0d", i - 2), dexp[i-2], sexp[i-2]);
        end
        step(); chk_idle("t2.post");

        // Extra shift plus negative zero point: 12.5 -> 13, minus 3.
        beat(100); cfgv(32'h4000_0000, 5'd2, -8'sd3); step();
        idle(); step(); step();
        chk_out("t3", 10, 0);

        // Extremes: full-scale products, zero scale, maximum shift rounding.
        beat(32'h8000_0000); cfgv(32'h7FFF_FFFF, 5'd0, 8'sd0); step();
        beat(32'h7FFF_FFFF); step();
        beat(12345); cfgv(32'h0000_0000, 5'd0, -8'sd7); step();
        chk_out("t4.minint", -128, 1);
        beat(32'h8000_0000); cfgv(32'h4000_0000, 5'd31, 8'sd5); step();
        chk_out("t4.maxint", 127, 1);
        idle(); step(); chk_out("t4.scale0", -7, 0);
        step();         chk_out("t4.shift31", 5, 0);

        // Config change travels with its beat; stored config updates after.
        cfgv(32'h4000_0000, 5'd0, 8'sd0); data_valid_i = 1'b0; step();
        beat(20); step();
        beat(20); cfgv(32'h2000_0000, 5'd0, 8'sd0); step();
        beat(20); step(); chk_out("t5.cfgA", 10, 0);
        idle();   step(); chk_out("t5.bypass", 5, 0);
        step();           chk_out("t5.stored", 5, 0);
        step();           chk_idle("t5.post");

        // Unconfigured beat after reset is dropped.
        rst_i = 1'b1; idle(); step();
        rst_i = 1'b0;
        beat(7); step();
        chk("t6.drop", 32'(drop_o), 1);
        idle(); step(); step(); chk_idle("t6.nobeat");
        step(); chk_idle("t6.nobeat2");
        chk("t6.cfg_loaded", 32'(cfg_loaded_o), 0);
        cfgv(32'h4000_0000, 5'd0, 8'sd1); step();
        beat(8); step();
        idle(); step(); step();
        chk_out("t6.after_cfg", 5, 0);
        chk("t6.drop_sticky", 32'(drop_o), 1);

        // Reset mid-stream discards in-flight beats and clears status.
        beat(1); step();
        beat(2); step();
        beat(3); step(); chk_out("t7.b0", 2, 0);
        rst_i = 1'b1; idle(); step();
        rst_i = 1'b0;
        chk_idle("t7.r0");
        chk("t7.cfg_loaded", 32'(cfg_loaded_o), 0);
        chk("t7.drop", 32'(drop_o), 0);
        step(); chk_idle("t7.r1");
        step(); chk_idle("t7.r2");
        step(); chk_idle("t7.r3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
